// File: rtl/reg_file.sv
// reg_file: 32 x N general-purpose register file, two combinational read
// ports and one synchronous write port. Register 0 always reads as zero and
// ignores writes.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset, clears all 32 registers
//   rs1, rs2    read addresses (port 1 feeds ALU A, port 2 feeds the B path)
//   rd          write address
//   reg_write   write enable
//   write_data  N-bit data to store at rd
//   read_data1  contents of rs1
//   read_data2  contents of rs2
//
// Build option: define REGFILE_BYPASS_EN for write-first reads. A read of the
// register being written in the same cycle then returns write_data directly
// instead of the old stored value. Only the read mux changes.
module reg_file #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  input  logic [4:0]   rd,
  input  logic         reg_write,
  input  logic [N-1:0] write_data,
  output logic [N-1:0] read_data1,
  output logic [N-1:0] read_data2
);

  logic [31:0][N-1:0] regs_q, regs_d;
  logic               wr_en;

  // A write to x0 is dropped here, so entry 0 holds zero from the first reset.
  assign wr_en = reg_write && (rd != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rd] = write_data;
  end

  // Reset takes priority over a write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so reads show the stored contents.
  logic fwd1, fwd2;
  assign fwd1 = wr_en && !rst && (rs1 == rd);
  assign fwd2 = wr_en && !rst && (rs2 == rd);

  // wr_en already excludes rd == 0, so a read of x0 never forwards.
  always_comb begin
    read_data1 = fwd1 ? write_data : regs_q[rs1];
    read_data2 = fwd2 ? write_data : regs_q[rs2];
    if (rs1 == 5'd0) read_data1 = '0;
    if (rs2 == 5'd0) read_data2 = '0;
  end
`else
  always_comb begin
    read_data1 = regs_q[rs1];
    read_data2 = regs_q[rs2];
    if (rs1 == 5'd0) read_data1 = '0;
    if (rs2 == 5'd0) read_data2 = '0;
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed, table-driven bench for reg_file (N = 32).
// Each table row is one clock cycle. The inputs are driven after a falling
// edge, the combinational outputs are checked before the next rising edge,
// and that rising edge commits the write or the reset. Two expectation sets
// per row cover the plain build and the bypass build.
module tb_reg_file;

  localparam int N = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   rs1 = '0, rs2 = '0, rd = '0;
  logic         reg_write = 1'b0;
  logic [N-1:0] write_data = '0;
  logic [N-1:0] read_data1, read_data2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file #(.N(N)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .write_data(write_data),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1, e2;   // expected without bypass
    logic [31:0] b1, b2;   // expected with bypass
    bit          chk;
    bit          alu;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    //          rst   we    rd     wd            rs1    rs2    e1            e2            b1            b2            chk alu
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1, 0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        1, 0};
    vecs[3]  = '{1'b0, 1'b1, 5'd1,  32'h7,        5'd5,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0,        1, 0};
    vecs[4]  = '{1'b0, 1'b1, 5'd2,  32'hFFFFFFF9, 5'd1,  5'd2,  32'h7,        32'h0,        32'h7,        32'hFFFFFFF9, 1, 0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  32'h7,        32'hFFFFFFF9, 32'h7,        32'hFFFFFFF9, 1, 1};
    vecs[6]  = '{1'b0, 1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1, 0};
    vecs[7]  = '{1'b0, 1'b1, 5'd3,  32'h11111111, 5'd0,  5'd2,  32'h0,        32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1, 0};
    vecs[8]  = '{1'b0, 1'b1, 5'd3,  32'h22222222, 5'd3,  5'd1,  32'h11111111, 32'h7,        32'h22222222, 32'h7,        1, 0};
    vecs[9]  = '{1'b1, 1'b1, 5'd4,  32'hAAAA5555, 5'd3,  5'd4,  32'h22222222, 32'h0,        32'h22222222, 32'h0,        1, 0};
    vecs[10] = '{1'b0, 1'b1, 5'd9,  32'h0000FFFF, 5'd4,  5'd3,  32'h0,        32'h0,        32'h0,        32'h0,        1, 0};
    vecs[11] = '{1'b0, 1'b0, 5'd9,  32'h0,        5'd9,  5'd9,  32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 1, 0};
    vecs[12] = '{1'b0, 1'b1, 5'd31, 32'h1,        5'd9,  5'd31, 32'h0000FFFF, 32'h0,        32'h0000FFFF, 32'h1,        1, 0};
    vecs[13] = '{1'b0, 1'b1, 5'd31, 32'h2,        5'd31, 5'd31, 32'h1,        32'h1,        32'h2,        32'h2,        1, 0};
    vecs[14] = '{1'b0, 1'b0, 5'd31, 32'h0,        5'd31, 5'd30, 32'h2,        32'h0,        32'h2,        32'h0,        1, 0};
    vecs[15] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h2,        32'h0,        32'h2,        1, 0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      reg_write  = vecs[i].we;
      rd         = vecs[i].rd;
      write_data = vecs[i].wd;
      rs1        = vecs[i].rs1;
      rs2        = vecs[i].rs2;
      #2;
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d_rd1", i), read_data1, BYP ? vecs[i].b1 : vecs[i].e1);
        chk($sformatf("vec%0d_rd2", i), read_data2, BYP ? vecs[i].b2 : vecs[i].e2);
      end
      if (vecs[i].alu) begin
        chk("alu_sum", read_data1 + read_data2, 32'h0);
        chk("alu_zero_flag", {31'h0, (read_data1 + read_data2) == 32'h0}, 32'h1);
      end
    end

    // Fill x1..x31 with distinct patterns, then read every register back
    // on both ports, which exposes address decode or aliasing faults.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      rst        = 1'b0;
      reg_write  = 1'b1;
      rd         = 5'(r);
      write_data = (32'h01000001 * r) ^ 32'hA5A50000;
    end
    @(negedge clk);
    reg_write  = 1'b1;
    rd         = 5'd0;
    write_data = 32'hFFFFFFFF;
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      reg_write = 1'b0;
      rs1 = 5'(r);
      rs2 = 5'(31 - r);
      #2;
      chk($sformatf("fill_rd1_x%0d", r), read_data1,
          (r == 0) ? 32'h0 : ((32'h01000001 * r) ^ 32'hA5A50000));
      chk($sformatf("fill_rd2_x%0d", 31 - r), read_data2,
          (r == 31) ? 32'h0 : ((32'h01000001 * (31 - r)) ^ 32'hA5A50000));
    end

    // A single reset edge after the fill clears every register.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r);
      rs2 = 5'(r);
      #1;
      chk($sformatf("post_rst_x%0d", r), read_data1 | read_data2, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
